// File: rtl/systolic_feeder.sv
// systolic_feeder: captures one K-deep operand tile, then streams it to the
// left (A) and top (B) edges of an N x N systolic array with the diagonal
// skew the array needs (lane i delayed by i cycles). Lanes outside their
// valid window carry zeros so the PEs see no-ops.
module systolic_feeder #(
  parameter int N      = 4,
  parameter int K      = 4,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_W-1:0]   in_a,
  input  logic [N*DATA_W-1:0]   in_b,
  output logic [N*DATA_W-1:0]   a_out,
  output logic [N*DATA_W-1:0]   b_out,
  output logic                  pe_en,
  output logic                  busy,
  output logic                  done
);

  // S covers the K beats plus the N-1 skew cycles plus N-1 flush cycles.
  localparam int S   = K + 2 * N - 2;
  localparam int LCW = (K > 1) ? $clog2(K) : 1;
  localparam int SCW = $clog2(S + 1);

  typedef enum logic {
    LOAD,
    STREAM
  } state_t;

  state_t            state;
  logic [LCW-1:0]    load_cnt;
  logic [SCW-1:0]    st_cnt;
  logic [DATA_W-1:0] abuf [K][N];
  logic [DATA_W-1:0] bbuf [K][N];
  logic [N*DATA_W-1:0] a_next;
  logic [N*DATA_W-1:0] b_next;
  logic              accept;

  assign in_ready = (state == LOAD);
  assign busy     = (state == STREAM);
  assign accept   = in_valid && in_ready;

  // Tile buffers: written one beat per accept, never cleared (a discarded
  // partial tile is simply overwritten by the next load).
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        abuf[load_cnt][i] <= in_a[i*DATA_W +: DATA_W];
        bbuf[load_cnt][i] <= in_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Skew select: lane i shows beat (t - i) when that beat exists, else zero;
  // the difference is taken as a signed int so t < i cannot wrap into range.
  always_comb begin
    a_next = '0;
    b_next = '0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = int'(st_cnt) - i;
      if (d >= 0 && d < K) begin
        a_next[i*DATA_W +: DATA_W] = abuf[d[LCW-1:0]][i];
        b_next[i*DATA_W +: DATA_W] = bbuf[d[LCW-1:0]][i];
      end
    end
  end

  // Control FSM with registered lanes, enable and completion pulse; outputs
  // default to zero every cycle so nothing lingers after the stream ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD;
      load_cnt <= '0;
      st_cnt   <= '0;
      a_out    <= '0;
      b_out    <= '0;
      pe_en    <= 1'b0;
      done     <= 1'b0;
    end else begin
      a_out <= '0;
      b_out <= '0;
      pe_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            if (load_cnt == LCW'(K - 1)) begin
              state    <= STREAM;
              load_cnt <= '0;
              st_cnt   <= '0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
        end
        STREAM: begin
          a_out <= a_next;
          b_out <= b_next;
          pe_en <= 1'b1;
          if (st_cnt == SCW'(S - 1)) begin
            done   <= 1'b1;
            state  <= LOAD;
            st_cnt <= '0;
          end else begin
            st_cnt <= st_cnt + 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Testbench for systolic_feeder (N=4, K=4, DATA_W=8): directed tiles with
// hand-derived skew patterns, gapped loads, back-pressure, mid-stream reset
// and a small behavioural 4x4 PE array for the integration check.
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int K  = 4;
  localparam int DW = 8;
  localparam int S  = K + 2 * N - 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic        pe_en;
  logic        busy;
  logic        done;

  int vectors     = 0;
  int miscompares = 0;

  systolic_feeder #(.N(N), .K(K), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .a_out    (a_out),
    .b_out    (b_out),
    .pe_en    (pe_en),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Behavioural output-stationary PE array fed by the feeder lanes.
  logic [7:0]  ain  [N][N];
  logic [7:0]  bin  [N][N];
  logic [7:0]  areg [N][N];
  logic [7:0]  breg [N][N];
  logic [31:0] cacc [N][N];
  logic        pe_clr;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ain[i][j] = (j == 0) ? a_out[i*8 +: 8] : areg[i][j-1];
        bin[i][j] = (i == 0) ? b_out[j*8 +: 8] : breg[i-1][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        areg[i][j] <= ain[i][j];
        breg[i][j] <= bin[i][j];
        if (pe_clr)
          cacc[i][j] <= '0;
        else if (pe_en)
          cacc[i][j] <= cacc[i][j] + 32'(ain[i][j]) * 32'(bin[i][j]);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs, then advance to just after the next edge.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    tick();
  endtask

  // Beat k of a test tile: A lane i = 16k+i+1+off, B lane j = 16k+j+0x81+off.
  function automatic logic [31:0] beat(input int k, input int off, input bit is_b);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      v[i*8 +: 8] = 8'(16 * k + i + 1 + off + (is_b ? 'h80 : 0));
    return v;
  endfunction

  // Expected skewed lanes at stream step t.
  function automatic logic [31:0] skewed(input int t, input int off, input bit is_b);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      int d;
      d = t - i;
      if (d >= 0 && d < K)
        v[i*8 +: 8] = 8'(16 * d + i + 1 + off + (is_b ? 'h80 : 0));
    end
    return v;
  endfunction

  task automatic loadBeats(input int first, input int off);
    for (int k = first; k < K; k++) begin
      checkOutput($sformatf("ready_load_k%0d", k), 32'(in_ready), 32'd1);
      applyStimulus(1'b1, beat(k, off, 0), beat(k, off, 1));
    end
  endtask

  // Called in the cycle right after the last beat is accepted.
  task automatic checkStream(input string tag, input int off, input bit bp, input int next_off);
    checkOutput({tag, "_busy_pre"}, 32'(busy), 32'd1);
    checkOutput({tag, "_pe_pre"}, 32'(pe_en), 32'd0);
    checkOutput({tag, "_a_pre"}, a_out, 32'd0);
    checkOutput({tag, "_rdy_pre"}, 32'(in_ready), 32'd0);
    if (bp) applyStimulus(1'b1, $urandom, $urandom);
    else    applyStimulus(1'b0, '0, '0);
    for (int t = 0; t < S; t++) begin
      checkOutput($sformatf("%s_a_t%0d", tag, t), a_out, skewed(t, off, 0));
      checkOutput($sformatf("%s_b_t%0d", tag, t), b_out, skewed(t, off, 1));
      checkOutput($sformatf("%s_pe_t%0d", tag, t), 32'(pe_en), 32'd1);
      checkOutput($sformatf("%s_done_t%0d", tag, t), 32'(done), 32'(t == S - 1));
      checkOutput($sformatf("%s_busy_t%0d", tag, t), 32'(busy), 32'(t != S - 1));
      checkOutput($sformatf("%s_rdy_t%0d", tag, t), 32'(in_ready), 32'(t == S - 1));
      if (bp && t < S - 1) applyStimulus(1'b1, $urandom, $urandom);
      else if (bp)         applyStimulus(1'b1, beat(0, next_off, 0), beat(0, next_off, 1));
      else                 applyStimulus(1'b0, '0, '0);
    end
    checkOutput({tag, "_a_post"}, a_out, 32'd0);
    checkOutput({tag, "_b_post"}, b_out, 32'd0);
    checkOutput({tag, "_pe_post"}, 32'(pe_en), 32'd0);
    checkOutput({tag, "_done_post"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [6:0]  gap_pat;
    logic [31:0] ia;
    logic [31:0] ib;
    int          k;
    bit          seen_done;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    pe_clr   = 1'b1;

    // Reset values
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("rst_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_a", a_out, 32'd0);
    checkOutput("rst_b", b_out, 32'd0);
    checkOutput("rst_pe", 32'(pe_en), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);

    // Skew check with back-to-back beats
    loadBeats(0, 0);
    checkStream("skew", 0, 1'b0, 0);

    // Gapped load: valid pattern 1,0,0,1,1,0,1 (first element at bit 6)
    gap_pat = 7'b1001101;
    k = 0;
    for (int p = 6; p >= 0; p--) begin
      checkOutput($sformatf("gap_busy_p%0d", p), 32'(busy), 32'd0);
      if (gap_pat[p]) begin
        applyStimulus(1'b1, beat(k, 0, 0), beat(k, 0, 1));
        k++;
      end else begin
        applyStimulus(1'b0, 32'hdeadbeef, 32'hcafef00d);
      end
    end
    checkStream("gap", 0, 1'b0, 0);

    // Back-pressure; the beat shown in the done cycle starts the next tile
    loadBeats(0, 5);
    checkStream("bp", 5, 1'b1, 9);
    loadBeats(1, 9);
    checkStream("bp_next", 9, 1'b0, 0);

    // Reset while st_cnt = 3, then a fresh tile must show no residue
    loadBeats(0, 2);
    repeat (3) applyStimulus(1'b0, '0, '0);
    checkOutput("mid_pe_before", 32'(pe_en), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_a", a_out, 32'd0);
    checkOutput("mid_rst_b", b_out, 32'd0);
    checkOutput("mid_rst_pe", 32'(pe_en), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
    loadBeats(0, 7);
    checkStream("post_rst", 7, 1'b0, 0);

    // Array integration: A = identity, B = 1..16 row-major, so C = B
    pe_clr = 1'b1;
    repeat (N + 1) applyStimulus(1'b0, '0, '0);
    pe_clr = 1'b0;
    for (int kk = 0; kk < K; kk++) begin
      ia = '0;
      ib = '0;
      for (int i = 0; i < N; i++) begin
        ia[i*8 +: 8] = (i == kk) ? 8'd1 : 8'd0;
        ib[i*8 +: 8] = 8'(4 * kk + i + 1);
      end
      applyStimulus(1'b1, ia, ib);
    end
    seen_done = 1'b0;
    for (int c = 0; c < 30 && !seen_done; c++) begin
      seen_done = done;
      applyStimulus(1'b0, '0, '0);
    end
    checkOutput("int_done_seen", 32'(seen_done), 32'd1);
    repeat (2) applyStimulus(1'b0, '0, '0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        checkOutput($sformatf("int_c_%0d_%0d", i, j), cacc[i][j], 32'(4 * i + j + 1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
